// File: rtl/eeg_epoch_frontend_pkg.sv
// Shared types and defaults for the EEG epoch front end; EEG_SAMPLE_DEPTH is also used by the master.
package eeg_epoch_frontend_pkg;

    localparam int EEG_SAMPLE_DEPTH  = 16;
    localparam int SAMPLES_PER_EPOCH = 3840;
    localparam int FIFO_DEPTH        = 8;
    localparam int SAMPLE_GAP        = 2;

    typedef enum logic {
        FE_IDLE,
        FE_STREAM
    } FRONTEND_STATE_T;

endpackage

// File: rtl/eeg_epoch_frontend_if.sv
// ADC-in / master-out sample bus of the epoch front end; slave is the front end's view.
interface eeg_epoch_frontend_if #(
    parameter int W = eeg_epoch_frontend_pkg::EEG_SAMPLE_DEPTH
) ();
    logic         adc_valid;
    logic [W-1:0] adc_data;
    logic         adc_ready;
    logic         new_sleep_epoch;
    logic         new_eeg_sample;
    logic [W-1:0] eeg_sample;

    modport slave (
        input  adc_valid, adc_data,
        output adc_ready, new_sleep_epoch, new_eeg_sample, eeg_sample
    );

    modport master (
        output adc_valid, adc_data,
        input  adc_ready, new_sleep_epoch, new_eeg_sample, eeg_sample
    );
endinterface

// File: rtl/eeg_epoch_frontend_sample_fifo.sv
// Synchronous sample FIFO with registered dout (valid the cycle after pop); push on full is
// accepted only alongside a pop, otherwise ignored; pop on empty is ignored.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/eeg_epoch_frontend.sv
// Frames ADC samples into epochs of paced new_eeg_sample strobes; push-to-strobe >= 2 cycles, adc_ready = !full
// while streaming (overrun flagged on drop). Build option EEG_DECIMATE_EN averages sample pairs before the FIFO.
module eeg_epoch_frontend #(
    parameter int EEG_SAMPLE_DEPTH  = eeg_epoch_frontend_pkg::EEG_SAMPLE_DEPTH,
    parameter int SAMPLES_PER_EPOCH = eeg_epoch_frontend_pkg::SAMPLES_PER_EPOCH,
    parameter int FIFO_DEPTH        = eeg_epoch_frontend_pkg::FIFO_DEPTH,
    parameter int SAMPLE_GAP        = eeg_epoch_frontend_pkg::SAMPLE_GAP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eeg_epoch_frontend_if.slave  bus,
    input  logic                 start_epoch,
    input  logic                 inference_busy,
    input  logic                 err_clear,
    output logic                 overrun,
    output logic                 epoch_skipped
);
    import eeg_epoch_frontend_pkg::*;

    localparam int W  = EEG_SAMPLE_DEPTH;
    localparam int CW = $clog2(SAMPLES_PER_EPOCH + 1);
    localparam int GW = $clog2(SAMPLE_GAP + 1);
    localparam logic [CW-1:0] EPOCH_LEN  = CW'(SAMPLES_PER_EPOCH);
    localparam logic [CW-1:0] LAST_POP   = CW'(SAMPLES_PER_EPOCH - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(SAMPLE_GAP);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(SAMPLE_GAP - 1);

    FRONTEND_STATE_T state, state_nxt;
    logic [CW-1:0]   pushed_cnt, popped_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            in_stream, start_ok, take, push, pop, full, empty;
    logic            overrun_set, skip_set, nse_q, strobe_q;
    logic [W-1:0]    push_dat;

    assign in_stream = (state == FE_STREAM);
    assign start_ok  = (state == FE_IDLE) && start_epoch && !inference_busy;
    assign skip_set  = start_epoch && (in_stream || inference_busy);
    assign pop       = in_stream && !empty && (gap_cnt == '0);
    // Samples beyond the epoch length never reach the FIFO and never raise overrun.
    assign take      = in_stream && bus.adc_valid && (pushed_cnt < EPOCH_LEN);

`ifdef EEG_DECIMATE_EN
    logic         phase;
    logic [W-1:0] hold;
    logic [W:0]   pair_sum;

    assign pair_sum    = {1'b0, hold} + {1'b0, bus.adc_data};
    assign push_dat    = pair_sum[W:1];
    assign push        = take && phase && (!full || pop);
    assign overrun_set = take && phase && full && !pop;

    // A pair whose second half is dropped is lost entirely; pairing restarts on the next sample.
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            phase <= 1'b0;
            hold  <= '0;
        end else if (take) begin
            phase <= !phase;
            if (!phase) hold <= bus.adc_data;
        end
    end
`else
    assign push_dat    = bus.adc_data;
    assign push        = take && (!full || pop);
    assign overrun_set = take && full && !pop;
`endif

    sample_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start_ok),
        .push  (push),
        .din   (push_dat),
        .pop   (pop),
        .dout  (bus.eeg_sample),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FE_IDLE:   if (start_ok) state_nxt = FE_STREAM;
            FE_STREAM: if (pop && (popped_cnt == LAST_POP)) state_nxt = FE_IDLE;
            default:   state_nxt = FE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= FE_IDLE;
            pushed_cnt    <= '0;
            popped_cnt    <= '0;
            gap_cnt       <= '0;
            nse_q         <= 1'b0;
            strobe_q      <= 1'b0;
            overrun       <= 1'b0;
            epoch_skipped <= 1'b0;
        end else begin
            state    <= state_nxt;
            nse_q    <= in_stream;
            strobe_q <= pop;
            if (start_ok) begin
                pushed_cnt <= '0;
                popped_cnt <= '0;
                gap_cnt    <= GAP_LOAD;
            end else begin
                if (push) pushed_cnt <= pushed_cnt + CW'(1);
                if (pop) begin
                    popped_cnt <= popped_cnt + CW'(1);
                    gap_cnt    <= GAP_RELOAD;
                end else if (in_stream && (gap_cnt != '0)) begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
            end
            overrun       <= overrun_set || (overrun && !err_clear);
            epoch_skipped <= skip_set || (epoch_skipped && !err_clear);
        end
    end

    assign bus.new_sleep_epoch = nse_q;
    assign bus.new_eeg_sample  = strobe_q;
    assign bus.adc_ready       = in_stream ? !full : 1'b1;
endmodule

// File: tb/tb_eeg_epoch_frontend.sv
// Scoreboard bench for eeg_epoch_frontend built with a 16-sample epoch, 8-entry FIFO and 4-cycle strobe gap.
module tb_eeg_epoch_frontend;
    localparam int W = 16, SPE = 16, FD = 8, GAP = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start_epoch = 1'b0, inference_busy = 1'b0, err_clear = 1'b0;
    logic overrun, epoch_skipped;
    int   checks = 0, failures = 0;
    int   cyc = 0;

    eeg_epoch_frontend_if #(.W(W)) bus ();

    eeg_epoch_frontend #(
        .EEG_SAMPLE_DEPTH(W), .SAMPLES_PER_EPOCH(SPE), .FIFO_DEPTH(FD), .SAMPLE_GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .start_epoch(start_epoch),
        .inference_busy(inference_busy), .err_clear(err_clear),
        .overrun(overrun), .epoch_skipped(epoch_skipped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    int           nse_fall_cyc = -1;
    logic         nse_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.new_eeg_sample === 1'b1) begin
            got_q.push_back(bus.eeg_sample);
            got_cyc.push_back(cyc);
        end
        if (nse_prev && bus.new_sleep_epoch === 1'b0) nse_fall_cyc = cyc;
        nse_prev = (bus.new_sleep_epoch === 1'b1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_sb();
        exp_q.delete(); got_q.delete(); got_cyc.delete(); nse_fall_cyc = -1;
    endtask

    task automatic pulse_start();
        start_epoch = 1'b1; tick(); start_epoch = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] base, input int n, input int spacing, input int exp_lim);
        for (int i = 0; i < n; i++) begin
            bus.adc_valid = 1'b1;
            bus.adc_data  = base + W'(i);
            if (i < exp_lim) exp_q.push_back(base + W'(i));
            tick();
            bus.adc_valid = 1'b0;
            tick(spacing - 1);
        end
    endtask

    task automatic wait_epoch_end(output bit timed_out);
        int k = 0;
        while (bus.new_sleep_epoch !== 1'b0 && k < 400) begin tick(); k++; end
        timed_out = (k >= 400);
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        checks++; if (bus.adc_ready !== 1'b1) begin failures++; $display("FAIL reset_adc_ready got=%b exp=1", bus.adc_ready); end
        checks++; if (bus.new_sleep_epoch !== 1'b0) begin failures++; $display("FAIL reset_nse got=%b exp=0", bus.new_sleep_epoch); end
        checks++; if (bus.new_eeg_sample !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", bus.new_eeg_sample); end
        checks++; if (bus.eeg_sample !== '0) begin failures++; $display("FAIL reset_sample got=%h exp=0", bus.eeg_sample); end
        checks++; if (overrun !== 1'b0 || epoch_skipped !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overrun, epoch_skipped); end
        rst_n = 1'b1; tick(2);
    endtask

    // 20 samples every 4 cycles: first 16 stream out, the rest are dropped without a flag.
    task automatic test_epoch();
        int s0, last_cyc; bit to;
        clear_sb();
        pulse_start();
        s0 = cyc;
        feed(16'h1000, 20, 4, SPE);
        wait_epoch_end(to);
        checks++; if (to) begin failures++; $display("FAIL epoch_timeout got=timeout exp=end"); end
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL epoch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        checks++; if (got_cyc.size() == 0 || got_cyc[0] - s0 !== GAP + 1) begin failures++; $display("FAIL epoch_first_latency got=%0d exp=%0d", got_cyc.size() ? got_cyc[0] - s0 : -1, GAP + 1); end
        last_cyc = got_cyc.size() ? got_cyc[got_cyc.size()-1] : -9;
        checks++; if (nse_fall_cyc !== last_cyc + 1) begin failures++; $display("FAIL epoch_nse_fall got=%0d exp=%0d", nse_fall_cyc, last_cyc + 1); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [W-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL epoch_data got=%h exp=%h", g, e); end
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL epoch_overrun got=%b exp=0", overrun); end
        checks++; if (bus.new_sleep_epoch !== 1'b0) begin failures++; $display("FAIL epoch_idle got=%b exp=0", bus.new_sleep_epoch); end
    endtask

    task automatic test_skip();
        clear_sb();
        inference_busy = 1'b1;
        pulse_start();
        feed(16'h4000, 4, 2, 0);
        inference_busy = 1'b0;
        tick(10);
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL skip_strobes got=%0d exp=0", got_q.size()); end
        checks++; if (bus.new_sleep_epoch !== 1'b0) begin failures++; $display("FAIL skip_nse got=%b exp=0", bus.new_sleep_epoch); end
        checks++; if (epoch_skipped !== 1'b1) begin failures++; $display("FAIL skip_flag got=%b exp=1", epoch_skipped); end
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        checks++; if (epoch_skipped !== 1'b0) begin failures++; $display("FAIL skip_clear got=%b exp=0", epoch_skipped); end
    endtask

    // adc_valid every cycle: FIFO fills at cycle 10, then one push per pop (every 4th cycle) until 16 accepted.
    task automatic test_overrun();
        int first_low = -1; bit to; bit gap_bad = 1'b0;
        clear_sb();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (first_low < 0 && bus.adc_ready === 1'b0) first_low = i;
            if (i == 11) begin checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_first_drop got=%b exp=1", overrun); end end
            if (i == 14) begin checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_beats_clear got=%b exp=1", overrun); end end
            if (i == 21) begin checks++; if (epoch_skipped !== 1'b1) begin failures++; $display("FAIL ovr_skip_in_stream got=%b exp=1", epoch_skipped); end end
            if (i == 35 || i == 39) begin checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_silent_drop i=%0d got=%b exp=0", i, overrun); end end
            bus.adc_valid = 1'b1;
            bus.adc_data  = 16'h2000 + W'(i);
            err_clear     = (i == 13 || i == 34);
            start_epoch   = (i == 20);
            if (i < 10 || (i >= 12 && i <= 32 && i % 4 == 0)) exp_q.push_back(16'h2000 + W'(i));
            tick();
        end
        bus.adc_valid = 1'b0; err_clear = 1'b0; start_epoch = 1'b0;
        wait_epoch_end(to);
        checks++; if (to) begin failures++; $display("FAIL ovr_timeout got=timeout exp=end"); end
        checks++; if (first_low !== 10) begin failures++; $display("FAIL ovr_ready_drop got=%0d exp=10", first_low); end
        for (int k = 1; k < got_cyc.size(); k++) if (got_cyc[k] - got_cyc[k-1] != GAP) gap_bad = 1'b1;
        checks++; if (gap_bad) begin failures++; $display("FAIL ovr_strobe_gap got=uneven exp=%0d", GAP); end
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [W-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL ovr_data got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_sb();
        pulse_start();
        feed(16'h5000, 3, 4, 0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (bus.new_sleep_epoch !== 1'b0 || bus.new_eeg_sample !== 1'b0) begin failures++; $display("FAIL rmid_outputs got=%b%b exp=00", bus.new_sleep_epoch, bus.new_eeg_sample); end
        checks++; if (bus.adc_ready !== 1'b1 || bus.eeg_sample !== '0) begin failures++; $display("FAIL rmid_ready_data got=%b/%h exp=1/0", bus.adc_ready, bus.eeg_sample); end
        got_q.delete(); got_cyc.delete();
        feed(16'h5100, 4, 4, 0);
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL rmid_no_strobes got=%0d exp=0", got_q.size()); end
        clear_sb();
        pulse_start();
        feed(16'h3000, SPE, 4, SPE);
        wait_epoch_end(to);
        checks++; if (to || got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rmid_restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [W-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL rmid_data got=%h exp=%h", g, e); end
        end
    endtask

`ifdef EEG_DECIMATE_EN
    task automatic test_decimate();
        logic [W-1:0] vals [4];
        vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300; vals[3] = 16'd500;
        clear_sb();
        exp_q.push_back(16'd150); exp_q.push_back(16'd400);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            bus.adc_valid = 1'b1; bus.adc_data = vals[i]; tick();
            bus.adc_valid = 1'b0; tick(3);
        end
        tick(30);
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL dec_count got=%0d exp=2", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [W-1:0] e, g;
            e = exp_q.pop_front(); g = got_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL dec_data got=%0d exp=%0d", g, e); end
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask
`endif

    initial begin
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        test_reset();
        test_skip();
`ifdef EEG_DECIMATE_EN
        test_decimate();
`else
        test_epoch();
        test_overrun();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
